// File: rtl/gpio_link_pkg.sv
// gpio_link_pkg: shared types for the GPIO nibble link; GPIO_TX_CHECKSUM_EN adds a 4th checksum nibble per frame.
package gpio_link_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, WAIT_HI, WAIT_LO} state_e;
  typedef logic [3:0] digit_t;
`ifdef GPIO_TX_CHECKSUM_EN
  localparam int NIBBLES_PER_FRAME = 4;
`else
  localparam int NIBBLES_PER_FRAME = 3;
`endif
  localparam logic [1:0] LAST_IDX = 2'(NIBBLES_PER_FRAME - 1);
  typedef digit_t [NIBBLES_PER_FRAME-1:0] frame_t;
endpackage

// File: rtl/bin8_to_bcd3.sv
// bin8_to_bcd3: combinational 8-bit binary to three BCD digits.
module bin8_to_bcd3
  import gpio_link_pkg::*;
(
  input  logic [7:0] value_i,
  output digit_t     hundreds_o,
  output digit_t     tens_o,
  output digit_t     ones_o
);
  assign hundreds_o = 4'(value_i / 8'd100);
  assign tens_o     = 4'((value_i % 8'd100) / 8'd10);
  assign ones_o     = 4'(value_i % 8'd10);
endmodule

// File: rtl/result_gpio_transmitter.sv
// result_gpio_transmitter: sends an 8-bit result as BCD nibbles over a strobe/ack handshake.
// GPIO_TX_CHECKSUM_EN appends an XOR checksum nibble after the ones digit.
module result_gpio_transmitter
  import gpio_link_pkg::*;
#(
  parameter int SETUP_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] value,
  input  logic       host_ack,
  output logic [3:0] gpio_out,
  output logic       gpio_strobe,
  output logic       busy,
  output logic       done,
  output logic       error
);
  localparam int CW = $clog2((SETUP_CYCLES > TIMEOUT_CYCLES ? SETUP_CYCLES : TIMEOUT_CYCLES) + 1);
  localparam logic [CW-1:0] SETUP_LAST   = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d, idx_nx;
  frame_t frame_q, frame_d, frame_in;
  digit_t hun, ten, one, out_q, out_d;
  logic ack_m_q, ack_s_q;
  logic strobe_q, strobe_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic abort;
  bin8_to_bcd3 u_bcd (
    .value_i   (value),
    .hundreds_o(hun),
    .tens_o    (ten),
    .ones_o    (one)
  );
`ifdef GPIO_TX_CHECKSUM_EN
  assign frame_in = {hun ^ ten ^ one, one, ten, hun};
`else
  assign frame_in = {one, ten, hun};
`endif
  assign idx_nx = idx_q + 2'd1;
  // A wait state gives up when the awaited ack edge has not arrived in time.
  assign abort = (cnt_q == TIMEOUT_LAST) &&
                 ((state_q == WAIT_HI && !ack_s_q) || (state_q == WAIT_LO && ack_s_q));
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    frame_d  = frame_q;
    strobe_d = strobe_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = error_q;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        busy_d = 1'b0;
        if (start && !busy_q) begin
          frame_d = frame_in;
          idx_d   = '0;
          error_d = 1'b0;
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: if (cnt_q == SETUP_LAST) begin
        strobe_d = 1'b1;
        cnt_d    = '0;
        state_d  = WAIT_HI;
      end
      WAIT_HI: if (ack_s_q) begin
        strobe_d = 1'b0;
        cnt_d    = '0;
        state_d  = WAIT_LO;
      end
      WAIT_LO: if (!ack_s_q) begin
        cnt_d   = '0;
        done_d  = idx_q == LAST_IDX;
        idx_d   = idx_q == LAST_IDX ? idx_q : idx_nx;
        state_d = idx_q == LAST_IDX ? IDLE : SETUP;
      end
    endcase
    if (abort) begin
      state_d  = IDLE;
      cnt_d    = '0;
      strobe_d = 1'b0;
      busy_d   = 1'b0;
      error_d  = 1'b1;
    end
    // busy stays high through the done cycle, so a start coinciding with done is dropped.
    out_d = state_d == IDLE ? '0 : frame_d[idx_d];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      frame_q  <= '0;
      out_q    <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      ack_m_q  <= 1'b0;
      ack_s_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
      out_q    <= out_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      ack_m_q  <= host_ack;
      ack_s_q  <= ack_m_q;
    end
  end
  assign gpio_out    = out_q;
  assign gpio_strobe = strobe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
endmodule

// File: tb/tb_result_gpio_transmitter.sv
// tb_result_gpio_transmitter: table, random and corner-case checks of the GPIO result sender.
module tb_result_gpio_transmitter;
  localparam int SC = 4;
  localparam int TO = 100;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, host_ack = 1'b0;
  logic [7:0] value = 8'd0;
  logic [3:0] gpio_out;
  logic gpio_strobe, busy, done, error;
  int checks = 0, failures = 0;
  logic [3:0] got[$];
  int done_cnt = 0;
  logic prev_strobe = 1'b0;
  bit host_en = 1'b1;
  int ack_dly = 3;
  int hcnt = 0;
  typedef logic [3:0] nib_q_t[$];
  typedef struct {logic [7:0] v; logic [3:0] h, t, o;} vec_t;
  vec_t vecs[8];
  always #5 clk = ~clk;
  result_gpio_transmitter #(.SETUP_CYCLES(SC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .value(value), .host_ack(host_ack),
    .gpio_out(gpio_out), .gpio_strobe(gpio_strobe), .busy(busy), .done(done), .error(error)
  );
  initial forever @(negedge clk) begin
    if (gpio_strobe && !prev_strobe) got.push_back(gpio_out);
    if (done) done_cnt++;
    prev_strobe = gpio_strobe;
  end
  // Host follows the strobe level after ack_dly cycles of disagreement.
  initial forever @(negedge clk) begin
    if (!host_en) begin
      host_ack = 1'b0;
      hcnt = 0;
    end else if (gpio_strobe !== host_ack) begin
      hcnt++;
      if (hcnt >= ack_dly) begin
        host_ack = gpio_strobe;
        hcnt = 0;
      end
    end else hcnt = 0;
  end
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic nib_q_t model(int v);
    nib_q_t q;
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    q.push_back(4'(h));
    q.push_back(4'(t));
    q.push_back(4'(o));
`ifdef GPIO_TX_CHECKSUM_EN
    q.push_back(4'(h ^ t ^ o));
`endif
    return q;
  endfunction
  task automatic chk_frame(string nm, nib_q_t e);
    chk({nm, "_len"}, got.size(), e.size());
    for (int i = 0; i < e.size() && i < got.size(); i++) chk($sformatf("%s_n%0d", nm, i), int'(got[i]), int'(e[i]));
  endtask
  task automatic wait_end();
    int n;
    n = 0;
    while (!done && !error && n < 2000) begin
      step();
      n++;
    end
    chk("end_bound", int'(n < 2000), 1);
  endtask
  task automatic pulse_start(logic [7:0] v);
    value = v;
    start = 1'b1;
    step();
    start = 1'b0;
    value = 8'($urandom);
  endtask
  task automatic send(string nm, logic [7:0] v, nib_q_t e);
    int d0;
    got.delete();
    d0 = done_cnt;
    pulse_start(v);
    wait_end();
    step();
    step();
    chk_frame(nm, e);
    chk({nm, "_done"}, done_cnt - d0, 1);
    chk({nm, "_err"}, int'(error), 0);
    chk({nm, "_busy"}, int'(busy), 0);
  endtask
  initial begin
    int n, d0;
    nib_q_t e;
    logic [7:0] rv;
    vecs = '{'{8'd173, 4'd1, 4'd7, 4'd3}, '{8'd5, 4'd0, 4'd0, 4'd5}, '{8'd255, 4'd2, 4'd5, 4'd5},
             '{8'd0, 4'd0, 4'd0, 4'd0}, '{8'd100, 4'd1, 4'd0, 4'd0}, '{8'd42, 4'd0, 4'd4, 4'd2},
             '{8'd99, 4'd0, 4'd9, 4'd9}, '{8'd210, 4'd2, 4'd1, 4'd0}};
    repeat (3) step();
    chk("rst_out", int'(gpio_out), 0);
    chk("rst_strobe", int'(gpio_strobe), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(error), 0);
    reset = 1'b0;
    step();
    // Accept latency and strobe setup timing
    got.delete();
    d0 = done_cnt;
    pulse_start(8'd173);
    chk("t1_busy", int'(busy), 1);
    chk("t1_out0", int'(gpio_out), 1);
    chk("t1_strobe0", int'(gpio_strobe), 0);
    n = 1;
    while (!gpio_strobe && n < 50) begin
      step();
      n++;
    end
    chk("t1_strobe_lat", n, SC + 1);
    wait_end();
    step();
    step();
    chk_frame("t1", model(173));
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_err", int'(error), 0);
    foreach (vecs[i]) begin
      e.delete();
      e.push_back(vecs[i].h);
      e.push_back(vecs[i].t);
      e.push_back(vecs[i].o);
`ifdef GPIO_TX_CHECKSUM_EN
      e.push_back(vecs[i].h ^ vecs[i].t ^ vecs[i].o);
`endif
      send($sformatf("vec%0d", i), vecs[i].v, e);
    end
    for (int i = 0; i < 12; i++) begin
      ack_dly = $urandom_range(1, 4);
      rv = 8'($urandom_range(0, 255));
      send($sformatf("rnd%0d", i), rv, model(int'(rv)));
    end
    // Host silent: timeout abort
    host_en = 1'b0;
    got.delete();
    d0 = done_cnt;
    pulse_start(8'd77);
    n = 0;
    while (!gpio_strobe && n < 50) begin
      step();
      n++;
    end
    n = 0;
    while (!error && n < 300) begin
      step();
      n++;
    end
    chk("to_lat", n, TO);
    chk("to_strobe", int'(gpio_strobe), 0);
    chk("to_busy", int'(busy), 0);
    chk("to_out", int'(gpio_out), 0);
    chk("to_nodone", done_cnt - d0, 0);
    host_en = 1'b1;
    ack_dly = 3;
    step();
    got.delete();
    d0 = done_cnt;
    pulse_start(8'd42);
    chk("to_err_clr", int'(error), 0);
    wait_end();
    step();
    step();
    chk_frame("to_next", model(42));
    chk("to_next_done", done_cnt - d0, 1);
    // Reset while waiting for the tens ack to fall
    got.delete();
    d0 = done_cnt;
    pulse_start(8'd173);
    n = 0;
    while (!(got.size() == 2 && !gpio_strobe) && n < 200) begin
      step();
      n++;
    end
    chk("rs_reach", int'(n < 200), 1);
    reset = 1'b1;
    step();
    chk("rs_strobe", int'(gpio_strobe), 0);
    chk("rs_out", int'(gpio_out), 0);
    chk("rs_busy", int'(busy), 0);
    reset = 1'b0;
    repeat (10) step();
    chk("rs_nodone", done_cnt - d0, 0);
    send("rs_next", 8'd9, model(9));
    // Starts while busy and coinciding with done are ignored
    ack_dly = 2;
    got.delete();
    d0 = done_cnt;
    pulse_start(8'd210);
    n = 0;
    while (got.size() < 1 && n < 200) begin
      step();
      n++;
    end
    pulse_start(8'd99);
    n = 0;
    while (!done && n < 500) begin
      step();
      n++;
    end
    chk("sb_done_seen", int'(done), 1);
    pulse_start(8'd99);
    repeat (30) step();
    chk_frame("sb", model(210));
    chk("sb_done", done_cnt - d0, 1);
    chk("sb_busy", int'(busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
